stepper_dispatch_scheduler: RTL and testbench

Sits between the SCARA kinematic controller and the two joint stepper_motor drivers. It buffers per-segment step commands from the controller in a small FIFO and dispatches them to both joints with one shared start pulse. Before releasing the next segment it waits for both joints to report finished, then for a settle time. It sequences end-effector (pen) changes only while the arm is stationary. It drives the controller's stepperReady input and both drivers' new_in inputs.

---
 rtl/scara_pkg.sv | 25 ++
 rtl/stepper_dispatch_scheduler_seg_fifo.sv | 60 ++++++
 rtl/stepper_dispatch_scheduler.sv | 136 +++++++++++++
 tb/tb_stepper_dispatch_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scara_pkg.sv
// Shared types for the SCARA stepper dispatch path: scheduler states and the
// per-segment command record carried through the segment FIFO.
package scara_pkg;

    localparam int unsigned STEP_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PEN_WAIT,
        ISSUE,
        BLANK,
        RUN,
        SETTLE
    } sched_state_t;

    typedef struct packed {
        logic [STEP_W-1:0] steps1;
        logic              dir1;
        logic [STEP_W-1:0] steps2;
        logic              dir2;
        logic              pen;
    } seg_t;

endpackage

// File: rtl/stepper_dispatch_scheduler_seg_fifo.sv
// Segment FIFO: power-of-two depth, registered occupancy, synchronous flush.
// Full/empty come from the registered count, so a same-cycle pop never frees a slot for a push.
import scara_pkg::*;

module seg_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  seg_t                         din,
    output seg_t                         dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    seg_t             mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/stepper_dispatch_scheduler.sv
// Buffers controller step segments and releases them to both joint drivers with a
// shared start pulse, sequencing pen changes and post-move settling between segments.
import scara_pkg::*;

module stepper_dispatch_scheduler #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 50,
    parameter int unsigned PEN_CYCLES    = 2500000,
    parameter int unsigned BLANK_CYCLES  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       seg_valid,
    input  logic [STEP_W-1:0]          seg_steps1,
    input  logic                       seg_dir1,
    input  logic [STEP_W-1:0]          seg_steps2,
    input  logic                       seg_dir2,
    input  logic                       seg_pen,
    output logic                       seg_ready,
    input  logic                       flush,
    input  logic                       m1_finished,
    input  logic                       m2_finished,
    output logic                       motor_new,
    output logic [STEP_W-1:0]          m1_steps,
    output logic                       m1_dir,
    output logic [STEP_W-1:0]          m2_steps,
    output logic                       m2_dir,
    output logic                       pen_out,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow
);

    localparam int unsigned CNT_MAX_A = (PEN_CYCLES > SETTLE_CYCLES) ? PEN_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > BLANK_CYCLES) ? CNT_MAX_A : BLANK_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned BLANK_LAST = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;

    localparam logic [CNT_W-1:0] PEN_END    = CNT_W'(PEN_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'(BLANK_LAST);

    sched_state_t     state;
    sched_state_t     state_n;
    logic [CNT_W-1:0] cnt;
    logic             seg_pen_q;
    logic             pop;
    logic             load_pen;
    logic             zero_steps;
    logic             fifo_full;
    logic             fifo_empty;
    seg_t             fifo_din;
    seg_t             head;

    assign fifo_din = '{steps1: seg_steps1, dir1: seg_dir1, steps2: seg_steps2,
                        dir2: seg_dir2, pen: seg_pen};

    seg_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (seg_valid),
        .pop   (pop),
        .flush (flush),
        .din   (fifo_din),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign seg_ready  = !fifo_full;
    assign motor_new  = (state == ISSUE);
    assign busy       = (state != IDLE) || !fifo_empty;
    assign zero_steps = (m1_steps == '0) && (m2_steps == '0);

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        load_pen = 1'b0;
        unique case (state)
            IDLE: begin
                // No pop on a flush cycle: the flushed head must not escape as a dispatch.
                if (!fifo_empty && !flush) begin
                    pop     = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (seg_pen_q != pen_out) begin
                    load_pen = 1'b1;
                    state_n  = PEN_WAIT;
                end else if (zero_steps) begin
                    state_n = SETTLE;
                end else begin
                    state_n = ISSUE;
                end
            end
            PEN_WAIT: if (cnt == PEN_END) state_n = zero_steps ? SETTLE : ISSUE;
            ISSUE:    state_n = BLANK;
            BLANK:    if (cnt == BLANK_END) state_n = RUN;
            RUN:      if (m1_finished && m2_finished) state_n = SETTLE;
            SETTLE:   if (cnt == SETTLE_END) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            m1_steps  <= '0;
            m1_dir    <= 1'b0;
            m2_steps  <= '0;
            m2_dir    <= 1'b0;
            seg_pen_q <= 1'b0;
            pen_out   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n != state)
                cnt <= '0;
            else if (state == PEN_WAIT || state == BLANK || state == SETTLE)
                cnt <= cnt + 1'b1;
            if (pop) begin
                m1_steps  <= head.steps1;
                m1_dir    <= head.dir1;
                m2_steps  <= head.steps2;
                m2_dir    <= head.dir2;
                seg_pen_q <= head.pen;
            end
            if (load_pen) pen_out <= seg_pen_q;
            if (seg_valid && fifo_full && !flush) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stepper_dispatch_scheduler.sv
// Directed bench for stepper_dispatch_scheduler: stimulus queues the expected dispatch
// records, a negedge monitor pops and compares them on every motor_new pulse.
module tb_stepper_dispatch_scheduler;
    import scara_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SETTLE = 6;
    localparam int unsigned PENC   = 20;
    localparam int unsigned BLANKC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       seg_valid = 1'b0;
    logic [7:0] seg_steps1 = '0;
    logic       seg_dir1 = 1'b0;
    logic [7:0] seg_steps2 = '0;
    logic       seg_dir2 = 1'b0;
    logic       seg_pen = 1'b0;
    logic       flush = 1'b0;
    logic       m1_finished = 1'b0;
    logic       m2_finished = 1'b0;
    logic       seg_ready;
    logic       motor_new;
    logic [7:0] m1_steps;
    logic       m1_dir;
    logic [7:0] m2_steps;
    logic       m2_dir;
    logic       pen_out;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int   checks = 0;
    int   failures = 0;
    int   n_new = 0;
    int   n0 = 0;
    seg_t exp_q[$];
    seg_t mon_exp;
    seg_t mon_act;
    logic prev_new = 1'b0;

    stepper_dispatch_scheduler #(
        .DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE), .PEN_CYCLES(PENC), .BLANK_CYCLES(BLANKC)
    ) dut (
        .clk(clk), .reset(reset), .seg_valid(seg_valid),
        .seg_steps1(seg_steps1), .seg_dir1(seg_dir1),
        .seg_steps2(seg_steps2), .seg_dir2(seg_dir2), .seg_pen(seg_pen),
        .seg_ready(seg_ready), .flush(flush),
        .m1_finished(m1_finished), .m2_finished(m2_finished),
        .motor_new(motor_new), .m1_steps(m1_steps), .m1_dir(m1_dir),
        .m2_steps(m2_steps), .m2_dir(m2_dir), .pen_out(pen_out),
        .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] s1, input logic d1, input logic [7:0] s2,
                         input logic d2, input logic p);
        seg_valid  = 1'b1;
        seg_steps1 = s1;
        seg_dir1   = d1;
        seg_steps2 = s2;
        seg_dir2   = d2;
        seg_pen    = p;
    endtask

    task automatic expect_seg(input logic [7:0] s1, input logic d1, input logic [7:0] s2,
                              input logic d2, input logic p);
        exp_q.push_back('{steps1: s1, dir1: d1, steps2: s2, dir2: d2, pen: p});
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    // Scoreboard monitor: each start pulse must be single-cycle and carry the next expected record.
    always @(negedge clk) begin
        if (motor_new) begin
            n_new++;
            checks++;
            if (prev_new) begin
                failures++;
                $display("FAIL motor_new_width: got 2+ cycle pulse expected 1 cycle");
            end
            mon_act = '{steps1: m1_steps, dir1: m1_dir, steps2: m2_steps, dir2: m2_dir, pen: pen_out};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_dispatch: got motor_new with %h expected none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act != mon_exp) begin
                    failures++;
                    $display("FAIL dispatch_data: got %h expected %h", mon_act, mon_exp);
                end
            end
        end
        prev_new = motor_new;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg_ready", int'(seg_ready), 1);
        check("rst_fifo_count", int'(fifo_count), 0);
        check("rst_motor_new", int'(motor_new), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pen_out", int'(pen_out), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_m1_steps", int'(m1_steps), 0);
        reset = 1'b0;
        tick();

        // Single segment: latency, data, settle timing
        n0 = n_new;
        expect_seg(8'd10, 1'b1, 8'd5, 1'b0, 1'b0);
        drive(8'd10, 1'b1, 8'd5, 1'b0, 1'b0);
        tick();
        seg_valid = 1'b0;
        check("t1_count_after_push", int'(fifo_count), 1);
        tick();
        check("t1_no_new_in_load", int'(motor_new), 0);
        tick();
        check("t1_new_latency", int'(motor_new), 1);
        check("t1_m1_steps", int'(m1_steps), 10);
        check("t1_m2_steps", int'(m2_steps), 5);
        m1_finished = 1'b1;
        m2_finished = 1'b1;
        tick();
        check("t1_pulse_end", int'(motor_new), 0);
        repeat (3) tick();
        repeat (SETTLE) tick();
        check("t1_busy_in_settle", int'(busy), 1);
        tick();
        check("t1_idle_after_settle", int'(busy), 0);
        check("t1_dispatches", n_new - n0, 1);
        m1_finished = 1'b0;
        m2_finished = 1'b0;

        // Overflow: fill while the first segment is stuck in RUN
        n0 = n_new;
        for (int i = 0; i < 6; i++) begin
            drive(8'(20 + i), i[0], 8'(30 + i), ~i[0], 1'b0);
            if (i < 5) expect_seg(8'(20 + i), i[0], 8'(30 + i), ~i[0], 1'b0);
            tick();
            if (i == 4) begin
                check("t2_count_full", int'(fifo_count), 4);
                check("t2_ready_low", int'(seg_ready), 0);
                check("t2_no_overflow_yet", int'(overflow), 0);
            end
            if (i == 5) begin
                check("t2_overflow_set", int'(overflow), 1);
                check("t2_count_still_full", int'(fifo_count), 4);
            end
        end
        seg_valid = 1'b0;
        m1_finished = 1'b1;
        m2_finished = 1'b1;
        wait_idle("t2_drain_timeout", 400);
        check("t2_dispatches", n_new - n0, 5);
        check("t2_queue_empty", exp_q.size(), 0);
        check("t2_overflow_sticky", int'(overflow), 1);
        m1_finished = 1'b0;
        m2_finished = 1'b0;

        // Pen change after reset
        reset = 1'b1;
        #1;
        check("t3_overflow_cleared", int'(overflow), 0);
        tick();
        reset = 1'b0;
        n0 = n_new;
        expect_seg(8'd3, 1'b0, 8'd4, 1'b1, 1'b1);
        drive(8'd3, 1'b0, 8'd4, 1'b1, 1'b1);
        tick();
        seg_valid = 1'b0;
        tick();
        tick();
        check("t3_pen_out", int'(pen_out), 1);
        check("t3_no_new_yet", int'(motor_new), 0);
        repeat (PENC) tick();
        check("t3_no_new_before_end", int'(motor_new), 0);
        tick();
        check("t3_new_after_pen", int'(motor_new), 1);
        m1_finished = 1'b1;
        m2_finished = 1'b1;
        wait_idle("t3_idle_timeout", 200);
        check("t3_dispatches", n_new - n0, 1);

        // Zero-step segment followed by a real one
        n0 = n_new;
        expect_seg(8'd7, 1'b0, 8'd9, 1'b1, 1'b1);
        drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
        tick();
        drive(8'd7, 1'b0, 8'd9, 1'b1, 1'b1);
        tick();
        seg_valid = 1'b0;
        tick();
        check("t4_no_new_zero", int'(motor_new), 0);
        check("t4_busy", int'(busy), 1);
        check("t4_count", int'(fifo_count), 1);
        wait_idle("t4_idle_timeout", 200);
        check("t4_dispatches", n_new - n0, 1);
        check("t4_queue_empty", exp_q.size(), 0);
        m1_finished = 1'b0;
        m2_finished = 1'b0;

        // Flush with the first segment in RUN
        n0 = n_new;
        expect_seg(8'd11, 1'b1, 8'd12, 1'b0, 1'b1);
        drive(8'd11, 1'b1, 8'd12, 1'b0, 1'b1);
        tick();
        drive(8'd13, 1'b0, 8'd14, 1'b1, 1'b1);
        tick();
        drive(8'd15, 1'b1, 8'd16, 1'b1, 1'b1);
        tick();
        seg_valid = 1'b0;
        repeat (4) tick();
        check("t5_count_before_flush", int'(fifo_count), 2);
        flush = 1'b1;
        drive(8'd17, 1'b0, 8'd18, 1'b0, 1'b1);
        tick();
        flush = 1'b0;
        seg_valid = 1'b0;
        check("t5_count_flushed", int'(fifo_count), 0);
        check("t5_no_overflow", int'(overflow), 0);
        m1_finished = 1'b1;
        m2_finished = 1'b1;
        wait_idle("t5_idle_timeout", 200);
        repeat (10) tick();
        check("t5_dispatches", n_new - n0, 1);
        check("t5_queue_empty", exp_q.size(), 0);
        m1_finished = 1'b0;
        m2_finished = 1'b0;

        // Reset mid-run with two segments queued
        n0 = n_new;
        expect_seg(8'd21, 1'b0, 8'd22, 1'b1, 1'b1);
        drive(8'd21, 1'b0, 8'd22, 1'b1, 1'b1);
        tick();
        drive(8'd23, 1'b1, 8'd24, 1'b0, 1'b1);
        tick();
        drive(8'd25, 1'b0, 8'd26, 1'b0, 1'b1);
        tick();
        seg_valid = 1'b0;
        repeat (4) tick();
        check("t6_count_before_reset", int'(fifo_count), 2);
        reset = 1'b1;
        #1;
        check("t6_motor_new", int'(motor_new), 0);
        check("t6_fifo_count", int'(fifo_count), 0);
        check("t6_seg_ready", int'(seg_ready), 1);
        check("t6_pen_out", int'(pen_out), 0);
        check("t6_m1_steps", int'(m1_steps), 0);
        check("t6_busy", int'(busy), 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (10) tick();
        check("t6_dispatches", n_new - n0, 1);
        check("t6_idle", int'(busy), 0);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
